// File: rtl/key_pkg.sv
// Shared key indices and vector type for the key front end.
// The power key sits above the eight pad keys.
package key_pkg;
    localparam int NUM_KEYS_DEFAULT = 9;

    localparam int KEY_A      = 0;
    localparam int KEY_B      = 1;
    localparam int KEY_SELECT = 2;
    localparam int KEY_START  = 3;
    localparam int KEY_RIGHT  = 4;
    localparam int KEY_LEFT   = 5;
    localparam int KEY_UP     = 6;
    localparam int KEY_DOWN   = 7;
    localparam int KEY_POWER  = 8;

    typedef logic [NUM_KEYS_DEFAULT-1:0] key_vec_t;
endpackage

// File: rtl/key_debounce_cell.sv
// One key slice: two-flop synchroniser, short-press latch, clk_ce debounce
// counter and a registered edge interrupt lasting one clk_ce period.
module key_debounce_cell #(
    parameter int DEBOUNCE_TICKS = 4,
    parameter int CNT_W          = 8
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic clk_ce,
    input  logic key_raw,
    input  logic irq_on_release,
    output logic key_stable,
    output logic key_irq
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

    logic             sync1_q, sync2_q;
    logic             latch_q, latch_d;
    logic             stable_q, stable_d;
    logic             irq_q, irq_d;
    logic             sample;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sample   = sync2_q | latch_q;
        // a press seen on the same cycle as the clear must survive
        latch_d  = sync2_q | (latch_q & ~clk_ce);
        stable_d = stable_q;
        cnt_d    = cnt_q;
        irq_d    = irq_q;
        if (clk_ce) begin
            irq_d = 1'b0;
            if (sample == stable_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                stable_d = sample;
                cnt_d    = '0;
                irq_d    = sample | irq_on_release;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            latch_q  <= 1'b0;
            stable_q <= 1'b0;
            irq_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= key_raw;
            sync2_q  <= sync1_q;
            latch_q  <= latch_d;
            stable_q <= stable_d;
            irq_q    <= irq_d;
            cnt_q    <= cnt_d;
        end
    end

    assign key_stable = stable_q;
    assign key_irq    = irq_q;
endmodule

// File: rtl/key_irq_gen.sv
// Key front end: one independent debounce cell per key, outputs feed the
// key register read path and the interrupt controller.
module key_irq_gen
    import key_pkg::*;
#(
    parameter int NUM_KEYS       = NUM_KEYS_DEFAULT,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int CNT_W          = 8
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                clk_ce,
    input  logic [NUM_KEYS-1:0] keys_raw,
    input  logic [NUM_KEYS-1:0] irq_on_release,
    output logic [NUM_KEYS-1:0] keys_stable,
    output logic [NUM_KEYS-1:0] key_irqs
);
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce_cell #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
            .CNT_W         (CNT_W)
        ) u_cell (
            .clk_sys       (clk_sys),
            .reset_n       (reset_n),
            .clk_ce        (clk_ce),
            .key_raw       (keys_raw[i]),
            .irq_on_release(irq_on_release[i]),
            .key_stable    (keys_stable[i]),
            .key_irq       (key_irqs[i])
        );
    end
endmodule

// File: tb/tb_key_irq_gen.sv
// Bench for key_irq_gen: directed plan steps plus random stimulus, two
// instances (4-tick and 1-tick debounce) checked against a behavioural model.
module tb_key_irq_gen;
    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic       clk_ce  = 1'b0;
    logic [8:0] keys_raw = '0;
    logic [8:0] irq_on_release = '0;
    logic [8:0] st4, irq4, st1, irq1;

    int n_cmp  = 0;
    int n_fail = 0;
    int ce_per = 4;
    int ce_cnt = 0;

    // model: keys seen after the synchroniser, pressed-since-last-tick flag,
    // run length of consecutive ticks disagreeing with the accepted level
    bit m_s1[9], m_s2[9], m_pend[9];
    int m_run[2][9];
    bit m_stable[2][9], m_irq[2][9];
    int TICKS[2] = '{4, 1};

    key_irq_gen #(.NUM_KEYS(9), .DEBOUNCE_TICKS(4), .CNT_W(8)) u_dut4 (
        .clk_sys(clk_sys), .reset_n(reset_n), .clk_ce(clk_ce), .keys_raw(keys_raw),
        .irq_on_release(irq_on_release), .keys_stable(st4), .key_irqs(irq4));
    key_irq_gen #(.NUM_KEYS(9), .DEBOUNCE_TICKS(1), .CNT_W(8)) u_dut1 (
        .clk_sys(clk_sys), .reset_n(reset_n), .clk_ce(clk_ce), .keys_raw(keys_raw),
        .irq_on_release(irq_on_release), .keys_stable(st1), .key_irqs(irq1));

    initial forever #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] mvec(input int m, input bit want_irq);
        logic [8:0] v;
        for (int i = 0; i < 9; i++) v[i] = want_irq ? m_irq[m][i] : m_stable[m][i];
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 9; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_pend[i] = 0;
            for (int m = 0; m < 2; m++) begin
                m_run[m][i] = 0; m_stable[m][i] = 0; m_irq[m][i] = 0;
            end
        end
    endtask

    task automatic model_edge();
        bit smp;
        if (!reset_n) return;
        for (int i = 0; i < 9; i++) begin
            smp = m_s2[i] | m_pend[i];
            for (int m = 0; m < 2; m++) begin
                if (clk_ce) begin
                    m_irq[m][i] = 0;
                    if (smp == m_stable[m][i]) m_run[m][i] = 0;
                    else begin
                        m_run[m][i]++;
                        if (m_run[m][i] == TICKS[m]) begin
                            m_stable[m][i] = smp;
                            m_run[m][i]    = 0;
                            m_irq[m][i]    = smp | irq_on_release[i];
                        end
                    end
                end
            end
            m_pend[i] = clk_ce ? m_s2[i] : (m_pend[i] | m_s2[i]);
            m_s2[i] = m_s1[i];
            m_s1[i] = keys_raw[i];
        end
    endtask

    task automatic check_all();
        chk("u4.keys_stable", 32'(st4),  32'(mvec(0, 0)));
        chk("u4.key_irqs",    32'(irq4), 32'(mvec(0, 1)));
        chk("u1.keys_stable", 32'(st1),  32'(mvec(1, 0)));
        chk("u1.key_irqs",    32'(irq1), 32'(mvec(1, 1)));
    endtask

    task automatic step();
        clk_ce = (ce_cnt == ce_per - 1);
        ce_cnt = (ce_cnt + 1) % ce_per;
        @(posedge clk_sys);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_clear();
        #1;
        chk("reset.u4.stable", 32'(st4), 32'h0);
        chk("reset.u4.irq",    32'(irq4), 32'h0);
        chk("reset.u1.stable", 32'(st1), 32'h0);
        chk("reset.u1.irq",    32'(irq1), 32'h0);
        step();
        step();
        reset_n = 1'b1;
    endtask

    // ce ticks from the first synchronised sample until u4 accepts key idx
    task automatic measure(input int idx, output int ticks);
        bit done;
        ticks = 0;
        done  = 0;
        step();
        step();
        for (int k = 0; k < 200 && !done; k++) begin
            step();
            if (clk_ce) ticks++;
            if (st4[idx]) done = 1;
        end
        chk("measure.timeout", 32'(done), 32'h1);
    endtask

    initial begin
        int ticks, w;
        bit done;
        model_clear();
        #1;
        chk("por.u4.stable", 32'(st4), 32'h0);
        chk("por.u4.irq",    32'(irq4), 32'h0);
        step();
        reset_n = 1'b1;

        // 1: clean press, latency and irq width
        keys_raw[0] = 1'b1;
        measure(0, ticks);
        chk("t1.latency", 32'(ticks), 32'd4);
        chk("t1.irq_on", 32'(irq4[0]), 32'h1);
        w = 1;
        for (int k = 0; k < 20 && irq4[0]; k++) begin
            step();
            if (irq4[0]) w++;
        end
        chk("t1.irq_width", 32'(w), 32'd4);
        repeat (20) step();

        // 2: bouncing key never accepted by the 4-tick instance
        for (int p = 0; p < 8; p++) begin
            keys_raw[1] = ~keys_raw[1];
            for (int k = 0; k < 8; k++) begin
                step();
                chk("t2.bounce_stable", 32'(st4[1]), 32'h0);
                chk("t2.bounce_irq", 32'(irq4[1]), 32'h0);
            end
        end
        keys_raw[1] = 1'b0;
        repeat (16) step();
        keys_raw[1] = 1'b1;
        measure(1, ticks);
        chk("t2.latency", 32'(ticks), 32'd4);

        // 3: short press between ticks caught by the latch (1-tick instance)
        ce_per = 8; ce_cnt = 0;
        done = 0;
        for (int k = 0; k < 20 && !done; k++) begin step(); if (clk_ce) done = 1; end
        keys_raw[2] = 1'b1;
        repeat (3) step();
        keys_raw[2] = 1'b0;
        done = 0;
        for (int k = 0; k < 20 && !done; k++) begin step(); if (clk_ce) done = 1; end
        chk("t3.stable_rise", 32'(st1[2]), 32'h1);
        chk("t3.irq_rise", 32'(irq1[2]), 32'h1);
        ticks = 0; done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            step();
            if (clk_ce) ticks++;
            if (!st1[2]) done = 1;
        end
        chk("t3.release_ticks", 32'(ticks), 32'd1);
        chk("t3.no_release_irq", 32'(irq1[2]), 32'h0);
        ce_per = 4; ce_cnt = 0;

        // 4: power key release with and without release interrupt
        for (int r = 1; r >= 0; r--) begin
            keys_raw[8] = 1'b1;
            done = 0;
            for (int k = 0; k < 100 && !done; k++) begin step(); if (st4[8]) done = 1; end
            chk("t4.press", 32'(done), 32'h1);
            repeat (8) step();
            irq_on_release[8] = r[0];
            keys_raw[8] = 1'b0;
            done = 0;
            for (int k = 0; k < 100 && !done; k++) begin step(); if (!st4[8]) done = 1; end
            chk("t4.stable_fall", 32'(st4[8]), 32'h0);
            chk("t4.release_irq", 32'(irq4[8]), 32'(r[0]));
            repeat (8) step();
        end
        irq_on_release = '0;

        // 5: reset mid-count discards the partial debounce
        keys_raw[3] = 1'b1;
        done = 0;
        for (int k = 0; k < 60 && !done; k++) begin step(); if (m_run[0][3] == 2) done = 1; end
        chk("t5.reach_cnt2", 32'(done), 32'h1);
        do_reset();
        measure(3, ticks);
        chk("t5.latency_after_reset", 32'(ticks), 32'd4);

        // 6: all keys pressed together
        keys_raw = '0;
        repeat (40) step();
        chk("t6.idle", 32'(st4), 32'h0);
        keys_raw = 9'h1FF;
        done = 0;
        for (int k = 0; k < 100 && !done; k++) begin step(); if (st4 != 0) done = 1; end
        chk("t6.all_stable", 32'(st4), 32'h1FF);
        chk("t6.all_irq", 32'(irq4), 32'h1FF);

        // random phase
        for (int n = 0; n < 1500; n++) begin
            if (n % 100 == 0) begin ce_per = $urandom_range(1, 5); ce_cnt = 0; end
            for (int i = 0; i < 9; i++)
                if ($urandom_range(0, 9) == 0) keys_raw[i] = ~keys_raw[i];
            if ($urandom_range(0, 15) == 0) irq_on_release = 9'($urandom);
            if ($urandom_range(0, 399) == 0) do_reset();
            else step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
